// File: rtl/niosii_system_sysid_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : niosii_system_sysid_arb_pkg
//  Description : Shared types and constants for the system-ID slave arbiter.
//                Holds the arbiter state encoding, the system-ID data width,
//                the word addresses of the slave, and an index-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package niosii_system_sysid_arb_pkg;

    localparam int   SID_DATA_W  = 32;
    localparam logic SID_ID_WORD = 1'b0;   // word 0: system ID
    localparam logic SID_TS_WORD = 1'b1;   // word 1: build timestamp

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // Width of a requester index; kept at least 1 so a single-requester
    // build still has a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/niosii_system_sysid_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : niosii_system_rr_pick
//  Description : Combinational round-robin picker. Returns the lowest
//                requesting index at or after ptr, wrapping to the lowest
//                requesting index overall when none lies at or after ptr.
//  Ports       : req   in  NUM_REQ  request vector
//                ptr   in  IDX_W    round-robin start position
//                any   out 1        at least one request is set
//                grant out IDX_W    winning index (0 when any = 0)
//  Revision    : 1.0 - initial release
// ============================================================================
module niosii_system_rr_pick
    import niosii_system_sysid_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   grant
);

    always_comb begin
        any   = |req;
        grant = '0;
        // Wrap case first: lowest requesting index overall. Descending
        // iteration leaves the lowest match as the final assignment.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant = IDX_W'(i);
            end
        end
        // A request at or after ptr takes precedence over the wrapped one.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (IDX_W'(i) >= ptr)) begin
                grant = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/niosii_system_sysid_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : niosii_system_sysid_arbiter
//  Description : Shares one read-only system-ID slave between NUM_REQ
//                Avalon-MM read masters. After reset it reads word 0 once
//                and flags whether it equals EXPECTED_ID; afterwards the
//                requesters are served round-robin, one read per 3 cycles
//                (IDLE -> ISSUE -> RESP).
//  Ports       : clock             in   1            clock
//                reset             in   1            synchronous, active-high
//                req_read          in   NUM_REQ      read strobes
//                req_address       in   NUM_REQ      word address per requester
//                req_waitrequest   out  NUM_REQ      1 = command not accepted
//                req_readdatavalid out  NUM_REQ      1-cycle data pulse
//                req_readdata      out  32*NUM_REQ   requester i at [32i+31:32i]
//                sid_address       out  1            to system-ID slave
//                sid_readdata      in   32           from system-ID slave
//                boot_done         out  1            ID check complete (sticky)
//                id_ok             out  1            word 0 matched EXPECTED_ID
//  Revision    : 1.0 - initial release
// ============================================================================
module niosii_system_sysid_arbiter
    import niosii_system_sysid_arb_pkg::*;
#(
    parameter int                    NUM_REQ     = 2,
    parameter logic [SID_DATA_W-1:0] EXPECTED_ID = 32'h0000_0000
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_read,
    input  logic [NUM_REQ-1:0]              req_address,
    output logic [NUM_REQ-1:0]              req_waitrequest,
    output logic [NUM_REQ-1:0]              req_readdatavalid,
    output logic [SID_DATA_W*NUM_REQ-1:0]   req_readdata,
    output logic                            sid_address,
    input  logic [SID_DATA_W-1:0]           sid_readdata,
    output logic                            boot_done,
    output logic                            id_ok
);

    localparam int               IDX_W  = idx_width(NUM_REQ);
    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_t                          r_state;
    arb_state_t                          w_state_nxt;
    logic [IDX_W-1:0]                    r_rr_ptr;
    logic [IDX_W-1:0]                    r_grant;
    logic                                r_addr;
    logic [NUM_REQ-1:0][SID_DATA_W-1:0]  r_data;
    logic                                r_boot_done;
    logic                                r_id_ok;

    logic                                w_any;
    logic [IDX_W-1:0]                    w_pick;

    niosii_system_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req     (req_read),
        .ptr     (r_rr_ptr),
        .any     (w_any),
        .grant   (w_pick)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and Avalon handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        req_waitrequest   = '1;
        req_readdatavalid = '0;
        sid_address       = SID_ID_WORD;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt              = ST_RESP;
                sid_address              = r_addr;
                req_waitrequest[r_grant] = 1'b0;
            end
            ST_RESP: begin
                w_state_nxt                = ST_IDLE;
                req_readdatavalid[r_grant] = 1'b1;
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: boot check, grant capture, read data, round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_addr      <= 1'b0;
            r_data      <= '0;
            r_boot_done <= 1'b0;
            r_id_ok     <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    // sid_address is word 0 here, so sid_readdata is the ID.
                    r_id_ok     <= (sid_readdata == EXPECTED_ID);
                    r_boot_done <= 1'b1;
                end
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_addr  <= req_address[w_pick];
                    end
                end
                ST_ISSUE: begin
                    r_data[r_grant] <= sid_readdata;
                    // The requester after the one just served gets priority.
                    r_rr_ptr <= (r_grant == C_LAST) ? '0 : r_grant + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign req_readdata = r_data;
    assign boot_done    = r_boot_done;
    assign id_ok        = r_id_ok;

endmodule
`default_nettype wire
